// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the instruction decoder.
//   WORD   : word-slice macro, [15:0]
//   WIDTH  : datapath word width
//   alu_op_e     : opcode constants for the sixteen operations (1xxxx reserved)
//   shift_mode_e : mode select for alu_shift
`ifndef WORD
`define WORD [15:0]
`endif

package alu_pkg;

  localparam int unsigned WIDTH = 16;

  typedef enum logic [4:0] {
    OpAdd   = 5'b00000,
    OpSub   = 5'b00001,
    OpAnd   = 5'b00010,
    OpOr    = 5'b00011,
    OpXor   = 5'b00100,
    OpNot   = 5'b00101,
    OpNeg   = 5'b00110,
    OpShl   = 5'b00111,
    OpShr   = 5'b01000,
    OpSra   = 5'b01001,
    OpSlt   = 5'b01010,
    OpSltu  = 5'b01011,
    OpPassX = 5'b01100,
    OpPassY = 5'b01101,
    OpMul   = 5'b01110,
    OpEq    = 5'b01111
  } alu_op_e;

  typedef enum logic [1:0] {
    ShiftLeft  = 2'b00,
    ShiftRight = 2'b01,
    ShiftArith = 2'b10
  } shift_mode_e;

endpackage

// File: rtl/alu_shift.sv
// Barrel shifter used by the ALU.
//   a_i    : word to shift
//   amt_i  : shift amount (0..15)
//   mode_i : ShiftLeft / ShiftRight (logical) / ShiftArith (sign fill)
//   y_o    : shifted word (zero for the unused mode encoding)
module alu_shift #(
  parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [3:0]       amt_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] y_o
);
  import alu_pkg::*;

  always_comb begin
    y_o = '0;
    case (mode_i)
      ShiftLeft:  y_o = a_i << amt_i;
      ShiftRight: y_o = a_i >> amt_i;
      ShiftArith: y_o = $signed(a_i) >>> amt_i;
      default:    y_o = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Datapath ALU: one of sixteen operations on X and Y, registered into z.
//   z     : registered result, one cycle after the operands
//   ALUop : operation select (alu_op_e); 1xxxx is reserved and yields 0
//   X, Y  : operands; shifts use only Y[3:0]
//   clk   : rising-edge clock
//   reset : asynchronous active-high clear of z
module alu #(
  parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
  output logic [WIDTH-1:0] z,
  input  logic [4:0]       ALUop,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             clk,
  input  logic             reset
);
  import alu_pkg::*;

  logic [1:0]       shift_mode;
  logic [WIDTH-1:0] shift_res;
  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] z_q;

  always_comb begin
    shift_mode = ShiftLeft;
    if (ALUop == OpShr) begin
      shift_mode = ShiftRight;
    end else if (ALUop == OpSra) begin
      shift_mode = ShiftArith;
    end
  end

  alu_shift #(
    .WIDTH (WIDTH)
  ) u_shift (
    .a_i    (X),
    .amt_i  (Y[3:0]),
    .mode_i (shift_mode),
    .y_o    (shift_res)
  );

  // Any opcode that matches no item (reserved or unknown) falls to zero.
  always_comb begin
    result_d = '0;
    case (ALUop)
      OpAdd:   result_d = X + Y;
      OpSub:   result_d = X - Y;
      OpAnd:   result_d = X & Y;
      OpOr:    result_d = X | Y;
      OpXor:   result_d = X ^ Y;
      OpNot:   result_d = ~X;
      OpNeg:   result_d = '0 - X;
      OpShl:   result_d = shift_res;
      OpShr:   result_d = shift_res;
      OpSra:   result_d = shift_res;
      OpSlt:   result_d = {{(WIDTH-1){1'b0}}, ($signed(X) < $signed(Y))};
      OpSltu:  result_d = {{(WIDTH-1){1'b0}}, (X < Y)};
      OpPassX: result_d = X;
      OpPassY: result_d = Y;
      OpMul:   result_d = X * Y;
      OpEq:    result_d = {{(WIDTH-1){1'b0}}, (X == Y)};
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      z_q <= '0;
    end else begin
      z_q <= result_d;
    end
  end

  assign z = z_q;

endmodule

// File: tb/tb_alu.sv
module tb_alu;

  logic [15:0] z;
  logic [4:0]  ALUop;
  logic [15:0] X;
  logic [15:0] Y;
  logic        clk;
  logic        reset;

  alu #(
    .WIDTH (16)
  ) dut (
    .z     (z),
    .ALUop (ALUop),
    .X     (X),
    .Y     (Y),
    .clk   (clk),
    .reset (reset)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] exp;
    string       name;
  } item_t;

  item_t q[$];
  item_t mon_item;
  int    checks = 0;
  int    passed = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: z=%h expected %h", name, got, exp);
    end
  endtask

  // Reference model from the operation table, using plain integer arithmetic.
  function automatic logic [15:0] model(input int op, input int x, input int y);
    int     sx;
    int     sy;
    int     s;
    int     r;
    longint p;
    sx = (x >= 32768) ? x - 65536 : x;
    sy = (y >= 32768) ? y - 65536 : y;
    s  = y % 16;
    r  = 0;
    case (op)
      0:  r = x + y;
      1:  r = x - y;
      2:  r = x & y;
      3:  r = x | y;
      4:  r = x ^ y;
      5:  r = ~x;
      6:  r = -x;
      7:  r = x << s;
      8:  r = x >> s;
      9:  r = sx >>> s;
      10: r = (sx < sy) ? 1 : 0;
      11: r = (x < y) ? 1 : 0;
      12: r = x;
      13: r = y;
      14: begin
        p = longint'(x) * longint'(y);
        r = int'(p % 64'sd65536);
      end
      15: r = (x == y) ? 1 : 0;
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  // Drive one operation, record what z must show after the next edge.
  task automatic issue(input logic [4:0] op, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] exp, input string name);
    item_t it;
    ALUop = op;
    X     = x;
    Y     = y;
    it.exp  = exp;
    it.name = name;
    q.push_back(it);
    @(posedge clk);
    #2;
  endtask

  // Monitor: z is valid one edge after each issued operation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!reset && q.size() > 0) begin
        mon_item = q.pop_front();
        check(mon_item.name, z, mon_item.exp);
      end
    end
  end

  logic [15:0] corners [6];

  initial begin
    logic [4:0]  op;
    logic [15:0] rx;
    logic [15:0] ry;
    corners = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 16'h000F};

    ALUop = 5'd0;
    X     = 16'h0003;
    Y     = 16'h0004;
    reset = 1'b0;
    #1 reset = 1'b1;
    #2 check("reset_initial", z, 16'h0000);
    @(posedge clk);
    #2 check("reset_held_initial", z, 16'h0000);
    reset = 1'b0;

    issue(5'b00000, 16'h0003, 16'h0004, 16'h0007, "add");
    issue(5'b00000, 16'hFFFF, 16'h0001, 16'h0000, "add_wrap");
    issue(5'b00001, 16'h0001, 16'h0002, 16'hFFFF, "sub");
    issue(5'b00110, 16'h8000, 16'h1234, 16'h8000, "neg_min");
    issue(5'b00101, 16'h00FF, 16'hABCD, 16'hFF00, "not");
    issue(5'b00010, 16'hF0F0, 16'hFF00, 16'hF000, "and");
    issue(5'b00011, 16'hF0F0, 16'hFF00, 16'hFFF0, "or");
    issue(5'b00100, 16'hF0F0, 16'hFF00, 16'h0FF0, "xor");
    issue(5'b00111, 16'h0001, 16'h0013, 16'h0008, "shl_ymask");
    issue(5'b01000, 16'h8000, 16'h000F, 16'h0001, "shr");
    issue(5'b01001, 16'h8000, 16'h0004, 16'hF800, "sra");
    issue(5'b01010, 16'hFFFF, 16'h0001, 16'h0001, "slt");
    issue(5'b01011, 16'hFFFF, 16'h0001, 16'h0000, "sltu");
    issue(5'b01111, 16'h1234, 16'h1234, 16'h0001, "eq");
    issue(5'b01110, 16'h0100, 16'h0101, 16'h0100, "mul");
    issue(5'b10011, 16'h1234, 16'h5678, 16'h0000, "reserved");
    issue(5'b01100, 16'hBEEF, 16'h1234, 16'hBEEF, "passx");
    issue(5'b01101, 16'hBEEF, 16'h1234, 16'h1234, "passy");

    // Asynchronous reset between edges, held across two edges.
    issue(5'b00000, 16'h0003, 16'h0004, 16'h0007, "add_before_reset");
    reset = 1'b1;
    #1 check("reset_async", z, 16'h0000);
    @(posedge clk);
    #2 check("reset_hold_1", z, 16'h0000);
    @(posedge clk);
    #2 check("reset_hold_2", z, 16'h0000);
    reset = 1'b0;
    issue(5'b00001, 16'h0001, 16'h0002, 16'hFFFF, "after_reset");

    for (int i = 0; i < 300; i++) begin
      op = 5'($urandom_range(0, 31));
      rx = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
      ry = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
      issue(op, rx, ry, model(int'(op), int'(rx), int'(ry)), "random");
    end

    for (int i = 0; i < 5 && q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (q.size() > 0) begin
      checks++;
      $display("FAIL drain: pending=%0d expected 0", q.size());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
